// File: rtl/dequantization_if.sv
`default_nettype none
// ============================================================================
// Module  : dequantization_if
// Brief   : Stream and control bundle for the dequantization block.
// Revision: 1.0
// ============================================================================
interface dequantization_if #(
  parameter int IW = 16,
  parameter int OW = 34
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          scale_we;
  logic [IW-1:0] scale_in;
  logic          len_err;

  modport master (
    output in_valid, in_data, in_last, out_ready, scale_we, scale_in,
    input  in_ready, out_valid, out_data, out_last, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready, scale_we, scale_in,
    output in_ready, out_valid, out_data, out_last, len_err
  );
endinterface
`default_nettype wire

// File: rtl/dequantization.sv
`default_nettype none
// ============================================================================
// Module  : dequantization
// Brief   : Q8.8 -> Q18.16 streaming widener, 2-stage elastic pipeline with
//           vector framing check. Optional scaling with DEQUANT_SCALE_EN.
// Revision: 1.0
// ============================================================================
module dequantization #(
  parameter int INPUT_INTEGER_WIDTH  = 8,
  parameter int INPUT_DECIMAL_WIDTH  = 8,
  parameter int OUTPUT_INTEGER_WIDTH = 18,
  parameter int OUTPUT_DECIMAL_WIDTH = 16,
  parameter int VEC_LEN              = 64
) (
  input wire clk,
  input wire rst_n,
  dequantization_if.slave bus
);

  localparam int c_iw    = INPUT_INTEGER_WIDTH + INPUT_DECIMAL_WIDTH;
  localparam int c_ow    = OUTPUT_INTEGER_WIDTH + OUTPUT_DECIMAL_WIDTH;
  localparam int c_cnt_w = $clog2(VEC_LEN);
  localparam int c_pad   = OUTPUT_DECIMAL_WIDTH - INPUT_DECIMAL_WIDTH;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(VEC_LEN - 1);

  localparam logic [0:0] c_empty = 1'b0;
  localparam logic [0:0] c_full  = 1'b1;

  logic [0:0] r_s1_state, r_s2_state;
  logic [0:0] w_s1_next, w_s2_next;
  logic       w_in_ready, w_in_fire, w_s2_load, w_s2_drain;

  logic [c_cnt_w-1:0]     r_elem_cnt;
  logic                   w_cnt_end;
  logic                   r_len_err;
  logic signed [c_iw-1:0] r_s1_data;
  logic                   r_s1_last;
  logic signed [c_ow-1:0] r_s2_data;
  logic                   r_s2_last;
  logic signed [c_ow-1:0] w_conv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_state <= c_empty;
      r_s2_state <= c_empty;
    end else begin
      r_s1_state <= w_s1_next;
      r_s2_state <= w_s2_next;
    end
  end

  // Stage 1 empties only by moving into stage 2; a refill in the same cycle wins.
  always_comb begin
    w_s1_next = r_s1_state;
    w_s2_next = r_s2_state;
    if (w_in_fire)       w_s1_next = c_full;
    else if (w_s2_load)  w_s1_next = c_empty;
    if (w_s2_load)       w_s2_next = c_full;
    else if (w_s2_drain) w_s2_next = c_empty;
  end

  always_comb begin
    w_in_ready = (r_s1_state == c_empty) || (r_s2_state == c_empty) || bus.out_ready;
    w_in_fire  = bus.in_valid && w_in_ready;
    w_s2_drain = (r_s2_state == c_full) && bus.out_ready;
    w_s2_load  = (r_s1_state == c_full) && ((r_s2_state == c_empty) || bus.out_ready);
  end

  assign w_cnt_end = (r_elem_cnt == c_cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem_cnt <= '0;
      r_len_err  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_last  <= 1'b0;
      r_s2_data  <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_data  <= bus.in_data;
        r_s1_last  <= w_cnt_end;
        r_elem_cnt <= w_cnt_end ? '0 : r_elem_cnt + 1'b1;
        if (bus.in_last != w_cnt_end) r_len_err <= 1'b1;
      end
      if (w_s2_load) begin
        r_s2_data <= w_conv;
        r_s2_last <= r_s1_last;
      end
    end
  end

`ifdef DEQUANT_SCALE_EN
  localparam int c_prod_dec = 2 * INPUT_DECIMAL_WIDTH;

  logic signed [c_iw-1:0]   r_scale;
  logic signed [2*c_iw-1:0] w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_scale <= c_iw'(1 << INPUT_DECIMAL_WIDTH);
    else if (bus.scale_we) r_scale <= bus.scale_in;
  end

  assign w_prod = r_s1_data * r_scale;

  generate
    if (c_prod_dec <= OUTPUT_DECIMAL_WIDTH) begin : g_align_pad
      assign w_conv = c_ow'(w_prod) <<< (OUTPUT_DECIMAL_WIDTH - c_prod_dec);
    end else begin : g_align_shr
      // Arithmetic shift truncates toward minus infinity.
      assign w_conv = c_ow'(w_prod >>> (c_prod_dec - OUTPUT_DECIMAL_WIDTH));
    end
  endgenerate
`else
  logic w_unused_scale;
  assign w_unused_scale = ^{bus.scale_we, bus.scale_in};

  assign w_conv = c_ow'(r_s1_data) <<< c_pad;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_s2_state == c_full);
  assign bus.out_data  = r_s2_data;
  assign bus.out_last  = r_s2_last;
  assign bus.len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_dequantization.sv
`default_nettype none
// ============================================================================
// Module  : tb_dequantization
// Brief   : Directed self-checking bench for dequantization.
// Revision: 1.0
// ============================================================================
module tb_dequantization;
  localparam int IW = 16;
  localparam int OW = 34;
  localparam int VL = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dequantization_if #(.IW(IW), .OW(OW)) bus ();

  dequantization #(
    .INPUT_INTEGER_WIDTH (8),
    .INPUT_DECIMAL_WIDTH (8),
    .OUTPUT_INTEGER_WIDTH(18),
    .OUTPUT_DECIMAL_WIDTH(16),
    .VEC_LEN             (VL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  logic [OW:0] out_q[$];
  int          out_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back({bus.out_last, bus.out_data});
        out_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) n_acc++;
    end
  end

  function automatic logic [OW-1:0] conv(input logic [IW-1:0] d);
    logic signed [OW-1:0] e;
    e = OW'($signed(d));
    return e <<< 8;
  endfunction

  function automatic logic [IW-1:0] pat(input int i, input int seed);
    return IW'(i * 1029 + seed * 4369 + 7);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [IW-1:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 50 && out_q.size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    check("out_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic stream_vec(input int seed, input int bad_idx);
    for (int i = 0; i < VL; i++) offer(pat(i, seed), (i == VL - 1) ^ (i == bad_idx));
  endtask

  task automatic check_vec(input int seed);
    wait_out(VL);
    for (int i = 0; i < VL && i < out_q.size(); i++)
      check($sformatf("vec%0d_e%0d", seed, i), 64'(out_q[i]), 64'({i == VL - 1, conv(pat(i, seed))}));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    bus.scale_we  = 1'b0;
    bus.scale_in  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_len_err",   64'(bus.len_err),   64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 45.5: visible after the second edge following the drive, single pulse
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h2D80;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("lat_e1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_e2_valid", 64'(bus.out_valid), 64'd1);
    check("lat_e2_data",  64'(bus.out_data),  64'(34'h0_002D_8000));
    @(posedge clk);
    #1;
    check("lat_e3_valid", 64'(bus.out_valid), 64'd0);

    // Negative values back to back
    offer(16'hFF80, 1'b0);
    offer(16'h8000, 1'b0);
    wait_out(3);
    if (out_q.size() == 3) begin
      check("pos_45p5",  64'(out_q[0]), 64'({1'b0, 34'h0_002D_8000}));
      check("neg_0p5",   64'(out_q[1]), 64'({1'b0, 34'h3_FFFF_8000}));
      check("neg_128",   64'(out_q[2]), 64'({1'b0, 34'h3_FF80_0000}));
    end

    // Full vector with correct framing
    do_reset();
    stream_vec(1, -1);
    check_vec(1);
    check("vec_len_err", 64'(bus.len_err), 64'd0);

    // Early in_last on element 10 is sticky
    for (int i = 0; i < 11; i++) offer(pat(i, 2), i == 10);
    check("len_err_set", 64'(bus.len_err), 64'd1);
    for (int i = 11; i < 16; i++) offer(pat(i, 2), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("len_err_hold", 64'(bus.len_err), 64'd1);

    // Backpressure: two accepted, then in_ready drops and output holds
    out_q.delete();
    out_cyc.delete();
    begin
      int base;
      base = n_acc;
      bus.out_ready = 1'b0;
      offer(pat(0, 3), 1'b0);
      offer(pat(1, 3), 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = pat(2, 3);
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("bp_accepted",  64'(n_acc - base),   64'd2);
      check("bp_in_ready",  64'(bus.in_ready),   64'd0);
      check("bp_out_valid", 64'(bus.out_valid),  64'd1);
      check("bp_hold_data", 64'(bus.out_data),   64'(conv(pat(0, 3))));
      check("bp_no_xfer",   64'(out_q.size()),   64'd0);
    end
    bus.out_ready = 1'b1;
    for (int i = 2; i < 5; i++) offer(pat(i, 3), 1'b0);
    wait_out(5);
    for (int i = 0; i < 5 && i < out_q.size(); i++)
      check($sformatf("bp_e%0d", i), 64'(out_q[i]), 64'({1'b0, conv(pat(i, 3))}));
    if (out_cyc.size() == 5) check("bp_contig", 64'(out_cyc[4] - out_cyc[0]), 64'd4);

    // Reset with both stages full, then a fresh vector
    bus.out_ready = 1'b0;
    offer(pat(5, 3), 1'b0);
    offer(pat(6, 3), 1'b0);
    check("mr_full_valid", 64'(bus.out_valid), 64'd1);
    check("mr_full_ready", 64'(bus.in_ready),  64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(bus.out_valid), 64'd0);
    check("mr_out_data",  64'(bus.out_data),  64'd0);
    check("mr_in_ready",  64'(bus.in_ready),  64'd1);
    check("mr_len_err",   64'(bus.len_err),   64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_q.delete();
    out_cyc.delete();
    bus.out_ready = 1'b1;
    stream_vec(4, -1);
    check_vec(4);
    check("mr_vec_len_err", 64'(bus.len_err), 64'd0);

    // Scale register
    do_reset();
    bus.scale_in = 16'h0200;
    bus.scale_we = 1'b1;
    @(posedge clk);
    #1 bus.scale_we = 1'b0;
`ifdef DEQUANT_SCALE_EN
    offer(16'h0180, 1'b0);
    bus.scale_in = 16'hFF00;
    bus.scale_we = 1'b1;
    @(posedge clk);
    #1 bus.scale_we = 1'b0;
    offer(16'h0080, 1'b0);
    wait_out(2);
    if (out_q.size() == 2) begin
      check("scale_x2",  64'(out_q[0]), 64'({1'b0, 34'h0_0003_0000}));
      check("scale_neg", 64'(out_q[1]), 64'({1'b0, 34'h3_FFFF_8000}));
    end
`else
    offer(16'h0180, 1'b0);
    wait_out(1);
    if (out_q.size() == 1)
      check("scale_ignored", 64'(out_q[0]), 64'({1'b0, 34'h0_0001_8000}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
